// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_pkg
// Shared types and constants for the branch predictor:
//   - bp_state_e  : INIT (entry-clear sweep) / RUN
//   - btb_entry_t : one BTB entry (valid, tag, target, is_jmp)
//   - CNT_INIT / CNT_MAX : 2-bit pattern history counter constants
// The tag and target fields are sized for the widest legal configuration;
// the top module zero-extends into them, so unused upper bits stay zero.
// ---------------------------------------------------------------------------
package branch_predictor_pkg;

    localparam int TAG_MAX = 30;
    localparam int TGT_MAX = 30;

    localparam logic [1:0] CNT_INIT = 2'b01;
    localparam logic [1:0] CNT_MAX  = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        logic [TGT_MAX-1:0] tgt;
        logic               is_jmp;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2
// Next-state function of a 2-bit saturating counter.
// Ports:
//   cnt_in  [1:0] in  : current counter value
//   inc_in        in  : 1 = count up (taken), 0 = count down (not taken)
//   cnt_out [1:0] out : saturated next value
// ---------------------------------------------------------------------------
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt_in,
    input  logic       inc_in,
    output logic [1:0] cnt_out
);

    always_comb begin
        cnt_out = cnt_in;
        if (inc_in) begin
            if (cnt_in != CNT_MAX) cnt_out = cnt_in + 2'd1;
        end else begin
            if (cnt_in != 2'b00) cnt_out = cnt_in - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Tagged direct-mapped BTB plus a PHT of 2-bit saturating counters.
// Fetch looks up `pc` combinationally; EX feeds resolved branches/jumps into
// a pending register whose write is applied on the following enabled edge.
// After reset an INIT sweep clears one entry per enabled cycle.
// Optional feature macro: BP_GSHARE_EN (PHT indexed by pc index XOR GHR).
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (global enable)
//   pc             : fetch PC          -> pred_taken, pred_target
//   ready          : high once the init sweep is done
//   ex_valid, ex_is_br, ex_taken, ex_pc, ex_target : resolved instruction
//   ex_pred_target : prediction for ex_pc (same function as pred_target)
// Handshake: ex_* is accepted on any clk_in edge where ex_valid, rdy_in and
// ready are all high; there is no back-pressure.
// ---------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 5,
    parameter int TAG_W = 13,
    parameter int TGT_W = 16,
    parameter int GHR_W = IDX_W
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        ready,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic        ex_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    output logic [31:0] ex_pred_target
);

    localparam int NUM = 1 << IDX_W;

    btb_entry_t  btb_q [NUM];
    btb_entry_t  btb_d [NUM];
    logic [1:0]  pht_q [NUM];
    logic [1:0]  pht_d [NUM];

    bp_state_e   state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic             pend_valid_q, pend_valid_d;
    logic             pend_is_br_q, pend_is_br_d;
    logic             pend_taken_q, pend_taken_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic [TAG_W-1:0] pend_tag_q, pend_tag_d;
    logic [TGT_W-1:0] pend_tgt_q, pend_tgt_d;

    logic [GHR_W-1:0] ghr_q;
`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_d;
`else
    // Without gshare the history is a constant zero and folds away.
    assign ghr_q = '0;
`endif

    // Only the index/tag/target bit fields of these buses are meaningful.
    logic unused_bits;
    assign unused_bits = ^{pc, ex_pc, ex_target};

    function automatic logic [32:0] predict(input btb_entry_t e,
                                            input logic [1:0] cnt,
                                            input logic [TAG_W-1:0] tag,
                                            input logic run);
        logic taken;
        taken = run && e.valid && (e.tag == TAG_MAX'(tag)) && (e.is_jmp || cnt[1]);
        return taken ? {1'b1, e.tgt, 2'b00} : 33'd0;
    endfunction

    // Fetch and EX lookups see registered contents only (no write bypass).
    logic [IDX_W-1:0] f_idx, f_pidx, x_idx, x_pidx, u_pidx;
    logic [32:0]      f_pred, x_pred;
    logic             run;

    assign run    = (state_q == ST_RUN);
    assign f_idx  = pc[IDX_W+1:2];
    assign x_idx  = ex_pc[IDX_W+1:2];
    assign f_pidx = f_idx ^ IDX_W'(ghr_q);
    assign x_pidx = x_idx ^ IDX_W'(ghr_q);
    // Update index uses the history as it stands before this update shifts it.
    assign u_pidx = pend_idx_q ^ IDX_W'(ghr_q);

    assign f_pred = predict(btb_q[f_idx], pht_q[f_pidx], pc[IDX_W+2+TAG_W-1:IDX_W+2], run);
    assign x_pred = predict(btb_q[x_idx], pht_q[x_pidx], ex_pc[IDX_W+2+TAG_W-1:IDX_W+2], run);

    assign pred_taken     = f_pred[32];
    assign pred_target    = f_pred[31:0];
    assign ex_pred_target = x_pred[31:0];
    assign ready          = run;

    logic [1:0] cnt_nxt;

    sat_counter2 u_cnt (
        .cnt_in  (pht_q[u_pidx]),
        .inc_in  (pend_taken_q),
        .cnt_out (cnt_nxt)
    );

    always_comb begin
        btb_d        = btb_q;
        pht_d        = pht_q;
        state_d      = state_q;
        ptr_d        = ptr_q;
        pend_valid_d = pend_valid_q;
        pend_is_br_d = pend_is_br_q;
        pend_taken_d = pend_taken_q;
        pend_idx_d   = pend_idx_q;
        pend_tag_d   = pend_tag_q;
        pend_tgt_d   = pend_tgt_q;
`ifdef BP_GSHARE_EN
        ghr_d        = ghr_q;
`endif
        // Reset has priority: a pending write caught by reset is dropped.
        if (rdy_in && !rst_in) begin
            if (state_q == ST_INIT) begin
                btb_d[ptr_q] = '0;
                pht_d[ptr_q] = CNT_INIT;
                ptr_d        = ptr_q + IDX_W'(1);
                if (ptr_q == '1) state_d = ST_RUN;
                pend_valid_d = 1'b0;
            end else begin
                if (pend_valid_q) begin
                    if (pend_is_br_q) begin
                        pht_d[u_pidx] = cnt_nxt;
                        // Not-taken never writes the BTB: misses stay misses,
                        // hits keep their entry.
                        if (pend_taken_q) begin
                            btb_d[pend_idx_q].valid  = 1'b1;
                            btb_d[pend_idx_q].tag    = TAG_MAX'(pend_tag_q);
                            btb_d[pend_idx_q].tgt    = TGT_MAX'(pend_tgt_q);
                            btb_d[pend_idx_q].is_jmp = 1'b0;
                        end
`ifdef BP_GSHARE_EN
                        ghr_d = GHR_W'({ghr_q, pend_taken_q});
`endif
                    end else begin
                        btb_d[pend_idx_q].valid  = 1'b1;
                        btb_d[pend_idx_q].tag    = TAG_MAX'(pend_tag_q);
                        btb_d[pend_idx_q].tgt    = TGT_MAX'(pend_tgt_q);
                        btb_d[pend_idx_q].is_jmp = 1'b1;
                    end
                end
                pend_valid_d = ex_valid;
                pend_is_br_d = ex_is_br;
                pend_taken_d = ex_taken;
                pend_idx_d   = ex_pc[IDX_W+1:2];
                pend_tag_d   = ex_pc[IDX_W+2+TAG_W-1:IDX_W+2];
                pend_tgt_d   = ex_target[TGT_W+1:2];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            pend_valid_q <= 1'b0;
`ifdef BP_GSHARE_EN
            ghr_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pend_valid_q <= pend_valid_d;
`ifdef BP_GSHARE_EN
            ghr_q        <= ghr_d;
`endif
        end
    end

    // Array and payload storage: cleared by the sweep, not by reset.
    always_ff @(posedge clk_in) begin
        btb_q        <= btb_d;
        pht_q        <= pht_d;
        pend_is_br_q <= pend_is_br_d;
        pend_taken_q <= pend_taken_d;
        pend_idx_q   <= pend_idx_d;
        pend_tag_q   <= pend_tag_d;
        pend_tgt_q   <= pend_tgt_d;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Randomised and directed stimulus against a table-level reference model of
// the predictor. Every cycle the expected outputs are queued; a monitor on
// the falling edge pops and compares them with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int NUM = 32;
    localparam int W   = 66;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic [31:0] pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ready;
    logic        ex_valid = 1'b0;
    logic        ex_is_br = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_target = '0;
    logic [31:0] ex_pred_target;

    branch_predictor dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ready          (ready),
        .ex_valid       (ex_valid),
        .ex_is_br       (ex_is_br),
        .ex_taken       (ex_taken),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_target (ex_pred_target)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    bit          m_known = 0;
    bit          m_run = 0;
    int          m_init_left = NUM;
    bit          m_valid [NUM];
    int unsigned m_tag   [NUM];
    int unsigned m_tgt   [NUM];
    bit          m_jmp   [NUM];
    int          m_cnt   [NUM];
    int unsigned m_ghr = 0;
    bit          m_pend_v = 0;
    bit          m_p_br, m_p_tk;
    logic [31:0] m_p_pc, m_p_tgt;

    function automatic int unsigned m_pidx(input int unsigned idx);
`ifdef BP_GSHARE_EN
        return (idx ^ m_ghr) & (NUM - 1);
`else
        return idx;
`endif
    endfunction

    function automatic logic [32:0] m_predict(input logic [31:0] a);
        int unsigned idx, tag;
        idx = (a >> 2) & (NUM - 1);
        tag = (a >> 7) & 32'h1FFF;
        if (!m_run) return 33'd0;
        if (m_valid[idx] && m_tag[idx] == tag && (m_jmp[idx] || m_cnt[m_pidx(idx)] >= 2))
            return {1'b1, m_tgt[idx]};
        return 33'd0;
    endfunction

    task automatic model_apply();
        int unsigned idx, p;
        idx = (m_p_pc >> 2) & (NUM - 1);
        if (m_p_br) begin
            p = m_pidx(idx);
            m_cnt[p] = m_p_tk ? ((m_cnt[p] < 3) ? m_cnt[p] + 1 : 3)
                              : ((m_cnt[p] > 0) ? m_cnt[p] - 1 : 0);
            if (m_p_tk) begin
                m_valid[idx] = 1; m_jmp[idx] = 0;
                m_tag[idx] = (m_p_pc >> 7) & 32'h1FFF;
                m_tgt[idx] = m_p_tgt & 32'h0003_FFFC;
            end
            m_ghr = ((m_ghr << 1) | m_p_tk) & (NUM - 1);
        end else begin
            m_valid[idx] = 1; m_jmp[idx] = 1;
            m_tag[idx] = (m_p_pc >> 7) & 32'h1FFF;
            m_tgt[idx] = m_p_tgt & 32'h0003_FFFC;
        end
    endtask

    task automatic model_edge();
        if (rst_in) begin
            m_known = 1; m_run = 0; m_init_left = NUM;
            m_pend_v = 0; m_ghr = 0;
            for (int i = 0; i < NUM; i++) begin
                m_valid[i] = 0; m_cnt[i] = 1; m_jmp[i] = 0;
            end
        end else if (rdy_in && m_known) begin
            if (!m_run) begin
                m_init_left--;
                if (m_init_left == 0) m_run = 1;
            end else begin
                if (m_pend_v) model_apply();
                m_pend_v = ex_valid; m_p_br = ex_is_br; m_p_tk = ex_taken;
                m_p_pc = ex_pc; m_p_tgt = ex_target;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    initial begin
        logic [W-1:0] exp, act;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {ready, pred_taken, pred_target, ex_pred_target};
                n_cmp++;
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL sb t=%0t got rdy=%b tk=%b tgt=%h ex=%h want rdy=%b tk=%b tgt=%h ex=%h",
                             $time, act[65], act[64], act[63:32], act[31:0],
                             exp[65], exp[64], exp[63:32], exp[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic [32:0] f, e;
        if (m_known) begin
            f = m_predict(pc);
            e = m_predict(ex_pc);
            exp_q.push_back({m_run, f, e[31:0]});
        end
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic dcheck(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_pred(input string name, input logic [31:0] a,
                            input logic tk, input logic [31:0] tgt);
        pc = a; #1;
        dcheck({name, "_tk"}, {31'd0, pred_taken}, {31'd0, tk});
        dcheck({name, "_tgt"}, pred_target, tgt);
    endtask

    task automatic ex_upd(input logic br, input logic tk, input logic [31:0] a, input logic [31:0] t);
        ex_valid = 1; ex_is_br = br; ex_taken = tk; ex_pc = a; ex_target = t;
        tick();
        ex_valid = 0;
    endtask

    task automatic sweep_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            #1; dcheck(name, {31'd0, ready}, 32'd0);
            tick();
        end
        #1; dcheck({name, "_done"}, {31'd0, ready}, 32'd1);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] a;
        a = $urandom & 32'hFFF0_0003;
        a = a | ($urandom_range(0, 2) << 7) | ($urandom_range(0, 3) << 2);
        return a;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_in = 1; rdy_in = 1; pc = 32'h1040;
        tick(); tick();
        rst_in = 0;

        // Reset timing: 32 cycles low, pred_taken low throughout.
        for (int i = 0; i < NUM; i++) begin
            #1; dcheck("init_ready", {31'd0, ready}, 32'd0);
            dcheck("init_pred", {31'd0, pred_taken}, 32'd0);
            tick();
        end
        #1; dcheck("ready_rise", {31'd0, ready}, 32'd1);

        // Taken branch: visible only after the second edge.
        ex_upd(1, 1, 32'h1040, 32'h1000);
        chk_pred("no_bypass", 32'h1040, 0, 32'h0);
        tick();
        chk_pred("taken_br", 32'h1040, 1, 32'h1000);

        // Saturation: 3 taken, 1 not taken -> still taken; 2nd not taken -> not.
        ex_upd(1, 1, 32'h1040, 32'h1000);
        ex_upd(1, 1, 32'h1040, 32'h1000);
        ex_upd(1, 1, 32'h1040, 32'h1000);
        ex_upd(1, 0, 32'h1040, 32'h0);
        tick();
        chk_pred("sat_10", 32'h1040, 1, 32'h1000);
        ex_upd(1, 0, 32'h1040, 32'h0);
        tick();
        chk_pred("sat_01", 32'h1040, 0, 32'h0);
        ex_pc = 32'h1040; #1;
        dcheck("ex_pred_nt", ex_pred_target, 32'h0);
        tick();

        // Tag conflict: jump at same index replaces the branch entry.
        ex_upd(0, 0, 32'h2040, 32'h3000);
        tick();
        chk_pred("conflict_old", 32'h1040, 0, 32'h0);
        chk_pred("conflict_jmp", 32'h2040, 1, 32'h3000);
        ex_pc = 32'h2040; #1;
        dcheck("ex_pred_jmp", ex_pred_target, 32'h3000);
        tick();

        // Stall mid-sweep: 10 rdy-low cycles delay ready by 10.
        rst_in = 1; tick(); rst_in = 0;
        for (int i = 0; i < 10; i++) tick();
        rdy_in = 0;
        for (int i = 0; i < 10; i++) begin
            ex_valid = 1; ex_is_br = 0; ex_pc = 32'h1040;
            #1; dcheck("stall_ready", {31'd0, ready}, 32'd0);
            tick();
        end
        ex_valid = 0; rdy_in = 1;
        sweep_check("stall_sweep", NUM - 10);

        // Reset at sweep pointer 20 restarts the full sweep.
        rst_in = 1; tick(); rst_in = 0;
        for (int i = 0; i < 20; i++) tick();
        rst_in = 1; tick(); rst_in = 0;
        sweep_check("restart_sweep", NUM);
        chk_pred("post_reset_clear", 32'h2040, 0, 32'h0);

`ifdef BP_GSHARE_EN
        // Alternating outcomes at one PC spread across PHT entries.
        for (int i = 0; i < 8; i++) begin
            ex_upd(1, (i % 2 == 0), 32'h5080, 32'h6000);
            pc = 32'h5080;
            tick();
        end
`endif

        // Randomised traffic checked by the scoreboard.
        for (int i = 0; i < 1500; i++) begin
            rst_in    = ($urandom_range(0, 399) == 0);
            rdy_in    = ($urandom_range(0, 9) != 0);
            pc        = rand_pc();
            ex_valid  = $urandom_range(0, 1);
            ex_is_br  = ($urandom_range(0, 3) != 0);
            ex_taken  = $urandom_range(0, 1);
            ex_pc     = rand_pc();
            ex_target = $urandom;
            tick();
        end
        rst_in = 0; ex_valid = 0;

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk_in);
        #1;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised successor to the fetch-stage direct-mapped BTB. It pairs a tagged branch target buffer with a separate pattern history table of 2-bit saturating counters. An entry-clear sweep after reset replaces the single-cycle array clear, and the write port is registered. Fetch queries it combinationally with the current `pc`; the EX stage feeds back resolved control-flow instructions and reads back the prediction made for `ex_pc`.

## Interface
Parameters:
- `IDX_W`, 5: log2 of entry count for both the BTB and the PHT.
- `TAG_W`, 13: BTB tag width, taken from `pc[IDX_W+2+TAG_W-1 : IDX_W+2]`.
- `TGT_W`, 16: stored target bits `target[TGT_W+1:2]`. Output target is `{zeros, stored, 2'b00}`.
- `GHR_W`, `IDX_W`: global history length. Used only under `BP_GSHARE_EN`; must be ≤ `IDX_W`.

Ports:
- `clk_in`  in  1  the only clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `rdy_in`  in  1  global enable. When low, all state holds: no sweep step, no update latch, no write.
- `pc`  in  32  fetch PC.
- `pred_taken`  out  1  fetch prediction.
- `pred_target`  out  32  predicted target; 0 when `pred_taken`=0.
- `ready`  out  1  high once the init sweep has finished.
- `ex_valid`  in  1  a resolved branch or jump is present in EX this cycle.
- `ex_is_br`  in  1  1 = conditional branch, 0 = unconditional jump.
- `ex_taken`  in  1  resolved direction; ignored when `ex_is_br`=0.
- `ex_pc`  in  32  PC of the resolved instruction.
- `ex_target`  in  32  resolved target.
- `ex_pred_target`  out  32  prediction for `ex_pc`, computed with the same function as `pred_target`, so EX can detect mispredicts.

## Operation
- Index: `pc[IDX_W+1:2]`.
- BTB entry fields: `valid`, `tag`, `tgt`, `is_jmp`.
- PHT entry: 2-bit counter. Reset/cleared value is 2'b01.
- Lookup:
  - hit = `valid` && tag match.
  - On a hit with `is_jmp`=1: predict taken.
  - On a hit with `is_jmp`=0: predict taken iff `pht[pidx][1]`.
  - Otherwise: not taken, target 0.
- Update stage: when `ex_valid`, `rdy_in` and state=RUN are all true, the inputs are latched into a pending register. The pending write is applied on the next `rdy_in` edge.
- Conditional branch update:
  - PHT counter saturates: taken → min(c+1, 3); not taken → max(c−1, 0).
  - If taken: write the BTB entry with valid=1, tag, tgt, `is_jmp`=0. This allocates on a miss and replaces on a conflict.
  - If not taken and the BTB misses: no BTB write.
  - If not taken and the BTB hits: the entry is kept.
- Jump update: write the BTB entry with `is_jmp`=1. The PHT is untouched.
- FSM states: INIT, RUN.
  - `rst_in` → INIT: pointer=0, pending update dropped, GHR=0.
  - INIT clears entry[ptr] each `rdy_in` cycle (valid=0, counter=01).
  - When ptr = 2^IDX_W−1, go to RUN. The pointer wraps to 0.
  - `ex_valid` is ignored in INIT.
  - `rst_in` asserted in RUN or mid-sweep restarts the sweep from 0.
- No lookup-to-write bypass: a lookup in the cycle the pending write is applied sees old contents.
- Two consecutive updates to the same index apply in order. No merging.

## Timing
- Reset values: `ready`=0, `pred_taken`=0, `pred_target`=0, `ex_pred_target`=0. All outputs are forced to 0 while in INIT.
- Init latency: exactly 2^IDX_W `rdy_in`-high cycles after reset deasserts. `ready` rises the cycle after the last clear.
- Lookup: combinational, same cycle as `pc`/`ex_pc`.
- Update: `ex_*` sampled at edge N, arrays written at edge N+1. The change is visible to lookups from cycle N+1 onward (after edge N+1).

## Configuration
- `BP_GSHARE_EN` defined:
  - PHT index = `pc[IDX_W+1:2] ^ {zeros, ghr}`.
  - GHR shifts in `ex_taken` on each applied conditional-branch update. Jumps leave the GHR unchanged.
  - The update index uses the GHR value before the shift.
  - Lookups use the committed GHR. No speculative history.
- Undefined: PHT index = BTB index. The GHR and its logic are absent.

## Structure
- Shared package holds the entry struct typedef, FSM state enum, and counter constants (`CNT_INIT`=2'b01, `CNT_MAX`=2'b11).
- One sub-module: `sat_counter2`, the 2-bit saturating next-state function.
- BTB and PHT arrays, FSM and update register live in the top module.

## Test plan
- Reset timing: deassert reset with `IDX_W`=5 and `rdy_in`=1 → `ready` low for 32 cycles, high on cycle 33. `pred_taken`=0 throughout.
- Taken branch: branch at 0x0000_1040 resolves taken to 0x0000_1000 → from the second cycle after it, `pc`=0x1040 gives `pred_taken`=1 (counter 10), `pred_target`=0x1000.
- Counter saturation: 3 more taken updates, then 1 not-taken → still predicts taken (counter 11→10). A second not-taken → `pred_taken`=0, while `ex_pred_target` with the same `ex_pc` stays 0.
- Tag conflict: a jump at 0x0000_2040 (same index, different tag) to 0x3000 → 0x1040 misses, 0x2040 predicts taken to 0x3000 regardless of its counter.
- Stall and reset mid-sweep: `rdy_in`=0 for 10 cycles mid-sweep → `ready` delayed by 10 cycles. `rst_in` pulsed at sweep pointer 20 → the full 32 cycles restart.
- Gshare (macro on): alternating taken/not-taken branch at one PC, 8 updates → same PC indexes different PHT entries; predictions follow the recorded pattern.
